tile_map_ram: RTL and testbench

Parametrised tile-map store for the snake game: holds one cell code per grid tile, serves a game-logic write port, a game-logic read port and a pipelined video lookup port, and runs multi-cycle CLEAR and BORDER fill commands. It sits between the game FSM and the VGA timing chain, replacing the fixed 32x24 grid with a RAM-inferable, sequentially initialised array.

---
 rtl/tile_map_pkg.sv | 27 ++
 rtl/tile_map_mem.sv | 33 +++
 rtl/tile_map_ram.sv | 232 +++++++++++++++++++++++
 tb/tb_tile_map_ram.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_map_pkg.sv
// tile_map_pkg
// Shared constants for the snake-game tile map: cell codes, the fixed
// colours for rock and snack tiles, command opcodes and the fill-walker
// state encoding.
package tile_map_pkg;

  // Cell codes stored in the tile RAM.
  localparam int CELL_NULL  = 0;
  localparam int CELL_SNAKE = 1;
  localparam int CELL_ROCK  = 2;
  localparam int CELL_SNACK = 4;

  localparam logic [11:0] COLOR_ROCK  = 12'h222;
  localparam logic [11:0] COLOR_SNACK = 12'hF00;

  typedef enum logic {
    OP_CLEAR  = 1'b0,
    OP_BORDER = 1'b1
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_BORDER = 2'd2
  } state_e;

endpackage

// File: rtl/tile_map_mem.sv
// tile_map_mem
// Single-write, dual-read synchronous RAM holding one cell code per tile.
// Port A serves game-logic reads, port B serves the video lookup. Reads are
// read-first: a read and write to the same address in one cycle return the
// old contents. The array is deliberately not reset so it maps onto block RAM.
//   clk              clock
//   we/waddr/wdata   write port
//   ra_addr/ra_data  read port A (data one cycle after address)
//   rb_addr/rb_data  read port B (data one cycle after address)
module tile_map_mem #(
  parameter int DEPTH = 768,
  parameter int AW    = 10,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] ra_addr,
  output logic [DW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    ra_data <= mem[ra_addr];
    rb_data <= mem[rb_addr];
  end

endmodule

// File: rtl/tile_map_ram.sv
// tile_map_ram
// Tile-map store for the snake game. Holds one cell code per grid tile and
// provides:
//   cmd_valid/cmd_op/cmd_fill/busy  multi-cycle CLEAR / BORDER fill commands
//   wr_en/wr_x/wr_y/wr_cell         game-logic write (ignored while busy)
//   rd_x/rd_y/rd_cell               game-logic read, 1-cycle latency
//   hcount/vcount/hsync_in/vsync_in/rgb_in/snake_color
//                                   video lookup input
//   hcount_out/vcount_out/hsync_out/vsync_out/rgb_out
//                                   video output, 2-cycle latency
//
// Fill walker states:
//   state     | meaning
//   ST_IDLE   | accepting game writes and new commands
//   ST_CLEAR  | writing fill code to every tile, one per cycle
//   ST_BORDER | walking every tile, writing ROCK on the outer ring only
module tile_map_ram
  import tile_map_pkg::*;
#(
  parameter int GRID_W    = 32,
  parameter int GRID_H    = 24,
  parameter int TILE_LOG2 = 5,
  parameter int CELL_W    = 4,
  parameter int COLOR_W   = 12,
  parameter int AW        = $clog2(GRID_W*GRID_H),
  parameter int XW        = $clog2(GRID_W),
  parameter int YW        = $clog2(GRID_H)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  input  logic               cmd_op,
  input  logic [CELL_W-1:0]  cmd_fill,
  output logic               busy,
  input  logic               wr_en,
  input  logic [XW-1:0]      wr_x,
  input  logic [YW-1:0]      wr_y,
  input  logic [CELL_W-1:0]  wr_cell,
  input  logic [XW-1:0]      rd_x,
  input  logic [YW-1:0]      rd_y,
  output logic [CELL_W-1:0]  rd_cell,
  input  logic [15:0]        hcount,
  input  logic [15:0]        vcount,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [COLOR_W-1:0] rgb_in,
  input  logic [COLOR_W-1:0] snake_color,
  output logic [15:0]        hcount_out,
  output logic [15:0]        vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic [COLOR_W-1:0] rgb_out
);

  localparam int DEPTH = GRID_W * GRID_H;

  function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x,
                                            input logic [YW-1:0] y);
    return AW'(AW'(y) * AW'(GRID_W) + AW'(x));
  endfunction

  state_e              state_q, state_d;
  logic [CELL_W-1:0]   fill_q, fill_d;
  logic [XW-1:0]       wx_q, wx_d;
  logic [YW-1:0]       wy_q, wy_d;

  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [CELL_W-1:0]   mem_wdata;
  logic                wr_in_range;
  logic                on_ring;

  logic                rd_inr_q, rd_inr_d;
  logic [AW-1:0]       rd_addr;
  logic [CELL_W-1:0]   ra_data;
  logic [CELL_W-1:0]   rb_data;

  logic [15:0]         tile_x, tile_y;
  logic                v1_inr_q, v1_inr_d;
  logic [AW-1:0]       v1_addr_q, v1_addr_d;
  logic [COLOR_W-1:0]  v1_rgb_q, v1_rgb_d;
  logic                v1_hs_q, v1_hs_d, v1_vs_q, v1_vs_d;
  logic [15:0]         v1_hc_q, v1_hc_d, v1_vc_q, v1_vc_d;
  logic                v2_inr_q, v2_inr_d;
  logic [COLOR_W-1:0]  v2_rgb_q, v2_rgb_d;
  logic                v2_hs_q, v2_hs_d, v2_vs_q, v2_vs_d;
  logic [15:0]         v2_hc_q, v2_hc_d, v2_vc_q, v2_vc_d;

  assign wr_in_range = (32'(wr_x) < GRID_W) && (32'(wr_y) < GRID_H);
  assign on_ring     = (wx_q == '0) || (wx_q == XW'(GRID_W-1)) ||
                       (wy_q == '0) || (wy_q == YW'(GRID_H-1));
  assign busy        = (state_q != ST_IDLE);

  // Walker FSM and write-port arbitration: the walker owns the write port
  // whenever a command runs, so game writes are simply not steered in.
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    wx_d      = wx_q;
    wy_d      = wy_q;
    mem_we    = 1'b0;
    mem_waddr = addr_of(wr_x, wr_y);
    mem_wdata = wr_cell;
    case (state_q)
      ST_IDLE: begin
        mem_we = wr_en && wr_in_range;
        if (cmd_valid) begin
          fill_d  = cmd_fill;
          wx_d    = '0;
          wy_d    = '0;
          state_d = (cmd_op == OP_BORDER) ? ST_BORDER : ST_CLEAR;
        end
      end
      ST_CLEAR, ST_BORDER: begin
        mem_waddr = addr_of(wx_q, wy_q);
        mem_wdata = (state_q == ST_CLEAR) ? fill_q : CELL_W'(CELL_ROCK);
        mem_we    = (state_q == ST_CLEAR) || on_ring;
        if (wx_q == XW'(GRID_W-1)) begin
          wx_d = '0;
          if (wy_q == YW'(GRID_H-1)) begin
            wy_d    = '0;
            state_d = ST_IDLE;
          end else begin
            wy_d = wy_q + 1'b1;
          end
        end else begin
          wx_d = wx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Out-of-range lookups are pointed at address 0 so the RAM index stays
  // legal; the registered in-range flag masks the result.
  always_comb begin
    rd_inr_d = (32'(rd_x) < GRID_W) && (32'(rd_y) < GRID_H);
    rd_addr  = rd_inr_d ? addr_of(rd_x, rd_y) : '0;

    tile_x    = hcount >> TILE_LOG2;
    tile_y    = vcount >> TILE_LOG2;
    v1_inr_d  = (tile_x < 16'(GRID_W)) && (tile_y < 16'(GRID_H));
    v1_addr_d = v1_inr_d ? addr_of(tile_x[XW-1:0], tile_y[YW-1:0]) : '0;
    v1_rgb_d  = rgb_in;
    v1_hs_d   = hsync_in;
    v1_vs_d   = vsync_in;
    v1_hc_d   = hcount;
    v1_vc_d   = vcount;

    v2_inr_d  = v1_inr_q;
    v2_rgb_d  = v1_rgb_q;
    v2_hs_d   = v1_hs_q;
    v2_vs_d   = v1_vs_q;
    v2_hc_d   = v1_hc_q;
    v2_vc_d   = v1_vc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      fill_q    <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      rd_inr_q  <= 1'b0;
      v1_inr_q  <= 1'b0;
      v1_addr_q <= '0;
      v1_rgb_q  <= '0;
      v1_hs_q   <= 1'b0;
      v1_vs_q   <= 1'b0;
      v1_hc_q   <= '0;
      v1_vc_q   <= '0;
      v2_inr_q  <= 1'b0;
      v2_rgb_q  <= '0;
      v2_hs_q   <= 1'b0;
      v2_vs_q   <= 1'b0;
      v2_hc_q   <= '0;
      v2_vc_q   <= '0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      wx_q      <= wx_d;
      wy_q      <= wy_d;
      rd_inr_q  <= rd_inr_d;
      v1_inr_q  <= v1_inr_d;
      v1_addr_q <= v1_addr_d;
      v1_rgb_q  <= v1_rgb_d;
      v1_hs_q   <= v1_hs_d;
      v1_vs_q   <= v1_vs_d;
      v1_hc_q   <= v1_hc_d;
      v1_vc_q   <= v1_vc_d;
      v2_inr_q  <= v2_inr_d;
      v2_rgb_q  <= v2_rgb_d;
      v2_hs_q   <= v2_hs_d;
      v2_vs_q   <= v2_vs_d;
      v2_hc_q   <= v2_hc_d;
      v2_vc_q   <= v2_vc_d;
    end
  end

  tile_map_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (CELL_W)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .ra_addr (rd_addr),
    .ra_data (ra_data),
    .rb_addr (v1_addr_q),
    .rb_data (rb_data)
  );

  assign rd_cell = rd_inr_q ? ra_data : CELL_W'(CELL_NULL);

  // Colour select sits after the RAM output register (stage 2).
  always_comb begin
    rgb_out = v2_rgb_q;
    if (v2_inr_q) begin
      if (rb_data == CELL_W'(CELL_SNAKE))      rgb_out = snake_color;
      else if (rb_data == CELL_W'(CELL_ROCK))  rgb_out = COLOR_W'(COLOR_ROCK);
      else if (rb_data == CELL_W'(CELL_SNACK)) rgb_out = COLOR_W'(COLOR_SNACK);
    end
  end

  assign hcount_out = v2_hc_q;
  assign vcount_out = v2_vc_q;
  assign hsync_out  = v2_hs_q;
  assign vsync_out  = v2_vs_q;

endmodule

// File: tb/tb_tile_map_ram.sv
module tb_tile_map_ram;

  localparam int GW = 32;
  localparam int GH = 24;
  localparam logic [11:0] SNAKE_RGB = 12'h0F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_op;
  logic [3:0]  cmd_fill;
  logic        busy;
  logic        wr_en;
  logic [4:0]  wr_x;
  logic [4:0]  wr_y;
  logic [3:0]  wr_cell;
  logic [4:0]  rd_x;
  logic [4:0]  rd_y;
  logic [3:0]  rd_cell;
  logic [15:0] hcount, vcount;
  logic        hsync_in, vsync_in;
  logic [11:0] rgb_in;
  logic [11:0] snake_color;
  logic [15:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out;
  logic [11:0] rgb_out;

  tile_map_ram dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_fill(cmd_fill), .busy(busy),
    .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y), .wr_cell(wr_cell),
    .rd_x(rd_x), .rd_y(rd_y), .rd_cell(rd_cell),
    .hcount(hcount), .vcount(vcount), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .rgb_in(rgb_in), .snake_color(snake_color),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    logic [15:0] hc;
    logic [15:0] vc;
  } vid_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   model [GW*GH];
  logic [3:0] rd_q [$];
  vid_t       vid_q [$];

  logic rd_issue = 1'b0, vid_issue = 1'b0;
  logic rd_v1 = 1'b0, vid_v1 = 1'b0, vid_v2 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_color(input int code, input logic [11:0] bg);
    case (code)
      1:       return SNAKE_RGB;
      2:       return 12'h222;
      4:       return 12'hF00;
      default: return bg;
    endcase
  endfunction

  // Issue flags travel with the request: 1 cycle for reads, 2 for video.
  always @(posedge clk) begin
    rd_v1  <= rd_issue;
    vid_v1 <= vid_issue;
    vid_v2 <= vid_v1;
  end

  always @(negedge clk) begin
    if (rd_v1) begin
      if (rd_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL rd_underflow: read output with no expected entry");
      end else begin
        logic [3:0] e;
        e = rd_q.pop_front();
        chk("rd_cell", 32'(rd_cell), 32'(e));
      end
    end
    if (vid_v2) begin
      if (vid_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL vid_underflow: video output with no expected entry");
      end else begin
        vid_t v;
        v = vid_q.pop_front();
        chk("rgb_out", 32'(rgb_out), 32'(v.rgb));
        chk("hsync_out", 32'(hsync_out), 32'(v.hs));
        chk("vsync_out", 32'(vsync_out), 32'(v.vs));
        chk("hcount_out", 32'(hcount_out), 32'(v.hc));
        chk("vcount_out", 32'(vcount_out), 32'(v.vc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    rd_issue  = 1'b0;
    vid_issue = 1'b0;
    wr_en     = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic issue_read_exp(input int x, input int y, input int e);
    rd_x = 5'(x);
    rd_y = 5'(y);
    rd_issue = 1'b1;
    rd_q.push_back(4'(e));
  endtask

  task automatic issue_read(input int x, input int y);
    int e;
    e = (x < GW && y < GH) ? model[y*GW + x] : 0;
    issue_read_exp(x, y, e);
  endtask

  task automatic do_write(input int x, input int y, input int c);
    wr_en = 1'b1;
    wr_x = 5'(x);
    wr_y = 5'(y);
    wr_cell = 4'(c);
    if (x < GW && y < GH) model[y*GW + x] = c;
  endtask

  task automatic issue_vid(input int h, input int v, input logic hs, input logic vs,
                           input logic [11:0] bg);
    vid_t e;
    int tx, ty;
    hcount = 16'(h); vcount = 16'(v);
    hsync_in = hs; vsync_in = vs; rgb_in = bg;
    vid_issue = 1'b1;
    tx = h / 32;
    ty = v / 32;
    e.rgb = (tx < GW && ty < GH) ? exp_color(model[ty*GW + tx], bg) : bg;
    e.hs = hs; e.vs = vs; e.hc = 16'(h); e.vc = 16'(v);
    vid_q.push_back(e);
  endtask

  task automatic fill_model(input int c);
    for (int i = 0; i < GW*GH; i++) model[i] = c;
  endtask

  task automatic start_cmd(input logic op, input int fill);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_fill  = 4'(fill);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    cmd_valid = 0; cmd_op = 0; cmd_fill = 0;
    wr_en = 0; wr_x = 0; wr_y = 0; wr_cell = 0;
    rd_x = 0; rd_y = 0;
    hcount = 0; vcount = 0; hsync_in = 0; vsync_in = 0; rgb_in = 0;
    snake_color = SNAKE_RGB;
    repeat (3) step();

    chk("reset_busy", 32'(busy), 0);
    chk("reset_rd_cell", 32'(rd_cell), 0);
    chk("reset_rgb_out", 32'(rgb_out), 0);
    chk("reset_hsync_out", 32'(hsync_out), 0);
    chk("reset_hcount_out", 32'(hcount_out), 0);
    rst = 1'b0;
    step();

    // CLEAR with fill 0: busy for exactly GW*GH cycles.
    start_cmd(1'b0, 0);
    step();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; step(); end
    chk("clear_busy_cycles", 32'(n), 768);
    fill_model(0);
    issue_read(0, 0);   step();
    issue_read(31, 23); step();
    issue_read(15, 12); step();

    // BORDER over the cleared map.
    start_cmd(1'b1, 0);
    step();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; step(); end
    chk("border_busy_cycles", 32'(n), 768);
    for (int x = 0; x < GW; x++) begin model[x] = 2; model[(GH-1)*GW + x] = 2; end
    for (int y = 0; y < GH; y++) begin model[y*GW] = 2; model[y*GW + GW-1] = 2; end
    issue_read(0, 5);  step();
    issue_read(31, 5); step();
    issue_read(7, 0);  step();
    issue_read(7, 23); step();
    issue_read(5, 5);  issue_vid(10, 10, 1'b0, 1'b1, 12'h555); step();

    // Game write then read back and view it.
    do_write(3, 2, 1); step();
    issue_read(3, 2); issue_vid(100, 70, 1'b1, 1'b0, 12'h123); step();

    // Out-of-range writes are dropped; out-of-range read gives NULL.
    do_write(0, 30, 4); step();
    do_write(5, 31, 4); step();
    issue_read(8, 30); step();
    issue_read(0, 0);  step();

    // CLEAR fill 5 with interference: write and command while busy, reads
    // mid-walk, and a command on the final busy cycle.
    start_cmd(1'b0, 5);
    step();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (n == 100) begin
        wr_en = 1'b1; wr_x = 5'd3; wr_y = 5'd2; wr_cell = 4'd4;
        start_cmd(1'b1, 0);
      end
      if (n == 101) issue_read_exp(0, 0, 5);
      if (n == 102) issue_read_exp(31, 23, 2);
      if (n == 768) start_cmd(1'b0, 15);
      step();
    end
    chk("clear5_busy_cycles", 32'(n), 768);
    step();
    chk("cmd_at_busy_fall_ignored", 32'(busy), 0);
    fill_model(5);
    issue_read(3, 2);   step();
    issue_read(10, 10); step();

    // Video pass-through outside the grid.
    issue_vid(1030, 10, 1'b1, 1'b0, 12'hABC); step();
    issue_vid(1030, 10, 1'b0, 1'b1, 12'hABC); step();
    repeat (3) step();

    // Reset in the middle of a CLEAR.
    start_cmd(1'b0, 3);
    step();
    n = 0;
    while (busy === 1'b1 && n < 99) begin n++; step(); end
    rst = 1'b1;
    step();
    chk("midreset_busy", 32'(busy), 0);
    chk("midreset_rd_cell", 32'(rd_cell), 0);
    chk("midreset_rgb_out", 32'(rgb_out), 0);
    rst = 1'b0;
    start_cmd(1'b0, 9);
    step();
    chk("post_reset_accept", 32'(busy), 1);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin n++; step(); end
    chk("post_reset_clear_cycles", 32'(n), 768);
    fill_model(9);

    // Random traffic against the model. Read expectation uses contents before
    // this cycle's write (read-first); video looks up the RAM a cycle later,
    // so it sees this cycle's write but not the next one.
    for (int i = 0; i < 400; i++) begin
      int codes [6];
      codes = '{0, 1, 2, 4, 3, 7};
      issue_read($urandom_range(31), $urandom_range(27));
      if ($urandom_range(1) == 1)
        do_write($urandom_range(31), $urandom_range(27), codes[$urandom_range(5)]);
      issue_vid($urandom_range(1200), $urandom_range(900),
                1'($urandom_range(1)), 1'($urandom_range(1)), 12'($urandom));
      step();
    end
    repeat (4) step();
    chk("rd_queue_drained", 32'(rd_q.size()), 0);
    chk("vid_queue_drained", 32'(vid_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
